hbm_write_arbiter: RTL

Shares one HBM AXI write port between NUM_REQ write engines (the hbm_dummy_write traffic generators and their successors). Grants AW requests round-robin and records grant order in an order FIFO. Steers each W burst from the recorded requester until WLAST, and routes B responses back by the requester index carried in the upper AWID bits. Sits between the per-engine AXI write masters and one HBM pseudo-channel port.

---
 rtl/hbm_axi_pkg.sv | 15 +
 rtl/hbm_rr_arbiter.sv | 36 +++
 rtl/hbm_write_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_axi_pkg.sv
// Shared AXI4 encodings and default write-channel attributes for the HBM
// write arbiter slice.
package hbm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AWSIZE_256B    = 3'b101;
  localparam logic [2:0] AWSIZE_512B    = 3'b110;

  localparam logic [1:0] AXI_LOCK_DEF   = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0000;
  localparam logic [2:0] AXI_PROT_DEF   = 3'b010;
  localparam logic [3:0] AXI_QOS_DEF    = 4'b0000;
  localparam logic [3:0] AXI_REGION_DEF = 4'b0000;

endpackage

// File: rtl/hbm_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant_i
// (modulo NUM_REQ) that is asserting, qualified by en_i.
module hbm_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_valid_o
);

  localparam int REQ_W = $clog2(NUM_REQ);

  int               cand;
  logic [REQ_W-1:0] cand_idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant_i) + off) % NUM_REQ;
      cand_idx = REQ_W'(cand);
      if (en_i && !gnt_valid_o && req_i[cand_idx]) begin
        gnt_valid_o     = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hbm_write_arbiter.sv
// Shares one HBM AXI write port between NUM_REQ engines: round-robin AW,
// W steered by an order FIFO, B routed by upper BID bits.
// Optional per-requester B counters: define HBM_WARB_PERF_CNT_EN.
module hbm_write_arbiter
  import hbm_axi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 33,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 5,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               s_axi_AWVALID,
  output logic [NUM_REQ-1:0]               s_axi_AWREADY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_axi_AWADDR,
  input  logic [NUM_REQ*ID_WIDTH-1:0]      s_axi_AWID,
  input  logic [NUM_REQ*8-1:0]             s_axi_AWLEN,
  input  logic [NUM_REQ*3-1:0]             s_axi_AWSIZE,
  input  logic [NUM_REQ-1:0]               s_axi_WVALID,
  output logic [NUM_REQ-1:0]               s_axi_WREADY,
  input  logic [NUM_REQ-1:0]               s_axi_WLAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_axi_WDATA,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  s_axi_WSTRB,
  output logic [NUM_REQ-1:0]               s_axi_BVALID,
  input  logic [NUM_REQ-1:0]               s_axi_BREADY,
  output logic [1:0]                       s_axi_BRESP,
  output logic [ID_WIDTH-1:0]              s_axi_BID,
  output logic                             m_axi_AWVALID,
  input  logic                             m_axi_AWREADY,
  output logic [ADDR_WIDTH-1:0]            m_axi_AWADDR,
  output logic [ID_WIDTH-1:0]              m_axi_AWID,
  output logic [7:0]                       m_axi_AWLEN,
  output logic [2:0]                       m_axi_AWSIZE,
  output logic [1:0]                       m_axi_AWBURST,
  output logic [1:0]                       m_axi_AWLOCK,
  output logic [3:0]                       m_axi_AWCACHE,
  output logic [2:0]                       m_axi_AWPROT,
  output logic [3:0]                       m_axi_AWQOS,
  output logic [3:0]                       m_axi_AWREGION,
  output logic                             m_axi_WVALID,
  input  logic                             m_axi_WREADY,
  output logic [DATA_WIDTH-1:0]            m_axi_WDATA,
  output logic [DATA_WIDTH/8-1:0]          m_axi_WSTRB,
  output logic                             m_axi_WLAST,
  input  logic                             m_axi_BVALID,
  output logic                             m_axi_BREADY,
  input  logic [1:0]                       m_axi_BRESP,
  input  logic [ID_WIDTH-1:0]              m_axi_BID,
  output logic [NUM_REQ*32-1:0]            perf_bcnt
);

  // Handshakes: a transfer happens on a rising clk edge where VALID and READY
  // are both high; VALID never waits on READY and payload is held until then.

  localparam int REQ_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(ORDER_DEPTH);
  localparam int LID_W  = ID_WIDTH - REQ_W;
  localparam logic [REQ_W:0] NUM_REQ_W = (REQ_W+1)'(NUM_REQ);

  logic                  aw_vld_q, aw_vld_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [REQ_W-1:0]      last_grant_q, last_grant_d;

  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  logic [REQ_W-1:0]      order_q [ORDER_DEPTH];
  logic                  fifo_empty, fifo_full, push, pop;
  logic [REQ_W-1:0]      head;

  logic                  aw_load;
  logic [NUM_REQ-1:0]    gnt;
  logic [REQ_W-1:0]      gnt_idx;
  logic                  gnt_valid;

  logic [REQ_W-1:0]      b_idx;
  logic                  b_known;
  logic                  unused_awid;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head       = order_q[rd_ptr_q[PTR_W-1:0]];

  // The slot may refill in the same cycle it is being accepted downstream.
  assign aw_load = rst_n && !fifo_full && (!aw_vld_q || m_axi_AWREADY);

  hbm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i        (s_axi_AWVALID),
    .en_i         (aw_load),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  assign s_axi_AWREADY = gnt;
  assign push          = gnt_valid;

  always_comb begin
    aw_vld_d     = aw_vld_q & ~m_axi_AWREADY;
    aw_addr_d    = aw_addr_q;
    aw_id_d      = aw_id_q;
    aw_len_d     = aw_len_q;
    aw_size_d    = aw_size_q;
    last_grant_d = last_grant_q;
    if (gnt_valid) begin
      aw_vld_d     = 1'b1;
      aw_addr_d    = s_axi_AWADDR[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      aw_id_d      = {gnt_idx, s_axi_AWID[int'(gnt_idx)*ID_WIDTH +: LID_W]};
      aw_len_d     = s_axi_AWLEN[int'(gnt_idx)*8 +: 8];
      aw_size_d    = s_axi_AWSIZE[int'(gnt_idx)*3 +: 3];
      last_grant_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_vld_q     <= 1'b0;
      aw_addr_q    <= '0;
      aw_id_q      <= '0;
      aw_len_q     <= '0;
      aw_size_q    <= '0;
      last_grant_q <= REQ_W'(NUM_REQ - 1);
    end else begin
      aw_vld_q     <= aw_vld_d;
      aw_addr_q    <= aw_addr_d;
      aw_id_q      <= aw_id_d;
      aw_len_q     <= aw_len_d;
      aw_size_q    <= aw_size_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < ORDER_DEPTH; i++) order_q[i] <= '0;
    end else begin
      if (push) begin
        order_q[wr_ptr_q[PTR_W-1:0]] <= gnt_idx;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign m_axi_AWVALID  = aw_vld_q;
  assign m_axi_AWADDR   = aw_addr_q;
  assign m_axi_AWID     = aw_id_q;
  assign m_axi_AWLEN    = aw_len_q;
  assign m_axi_AWSIZE   = aw_size_q;
  assign m_axi_AWBURST  = AXI_BURST_INCR;
  assign m_axi_AWLOCK   = AXI_LOCK_DEF;
  assign m_axi_AWCACHE  = AXI_CACHE_DEF;
  assign m_axi_AWPROT   = AXI_PROT_DEF;
  assign m_axi_AWQOS    = AXI_QOS_DEF;
  assign m_axi_AWREGION = AXI_REGION_DEF;

  // W follows the oldest granted requester; nothing moves with the FIFO empty.
  always_comb begin
    m_axi_WVALID = 1'b0;
    m_axi_WLAST  = 1'b0;
    m_axi_WDATA  = s_axi_WDATA[int'(head)*DATA_WIDTH +: DATA_WIDTH];
    m_axi_WSTRB  = s_axi_WSTRB[int'(head)*STRB_W +: STRB_W];
    s_axi_WREADY = '0;
    if (rst_n && !fifo_empty) begin
      m_axi_WVALID       = s_axi_WVALID[head];
      m_axi_WLAST        = s_axi_WLAST[head];
      s_axi_WREADY[head] = m_axi_WREADY;
    end
  end

  assign pop = m_axi_WVALID & m_axi_WREADY & m_axi_WLAST;

  assign b_idx   = m_axi_BID[ID_WIDTH-1 -: REQ_W];
  assign b_known = ({1'b0, b_idx} < NUM_REQ_W);

  // Responses for an unknown requester index are sunk so the port cannot hang.
  always_comb begin
    s_axi_BVALID = '0;
    m_axi_BREADY = 1'b0;
    if (rst_n) begin
      m_axi_BREADY = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (b_known && (b_idx == REQ_W'(i))) begin
          s_axi_BVALID[i] = m_axi_BVALID;
          m_axi_BREADY    = s_axi_BREADY[i];
        end
      end
    end
  end

  assign s_axi_BRESP = m_axi_BRESP;
  assign s_axi_BID   = {{REQ_W{1'b0}}, m_axi_BID[LID_W-1:0]};

  always_comb begin
    unused_awid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      unused_awid = unused_awid ^ (^s_axi_AWID[i*ID_WIDTH+LID_W +: REQ_W]);
  end

`ifdef HBM_WARB_PERF_CNT_EN
  logic [31:0] bcnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) bcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (s_axi_BVALID[i] && s_axi_BREADY[i]) bcnt_q[i] <= bcnt_q[i] + 32'd1;
    end
  end

  always_comb begin
    perf_bcnt = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_bcnt[i*32 +: 32] = bcnt_q[i];
  end
`else
  assign perf_bcnt = '0;
`endif

endmodule
